axis_pkt_rr_sched: RTL
======================

Name: axis_pkt_rr_sched

Overview:
- Packet-level round-robin scheduler that drives `bus_sel` of the AXI-stream FIFO output mux.
- Shares one downstream AXI-stream port between NUM_CH FIFO channels.
- Holds a grant from the first beat to the `tlast` beat, so packets never interleave.
- Routes downstream `tready` back to the granted FIFO only, and reports packet completions and watchdog aborts.

Parameters:
- NUM_CH, 4, number of FIFO channels; legal 1..127.
- MAX_BEATS, 1024, maximum beats per packet before the watchdog aborts the grant; legal 2..65535.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable; gates new grants only.
- ch_req  in  NUM_CH  per-channel "packet available" (FIFO non-empty), level-sensitive.
- axis_out_tvalid  in  1  `tvalid` seen at the mux output.
- axis_out_tlast  in  1  `tlast` seen at the mux output.
- axis_down_tready  in  1  downstream `tready`.
- bus_sel  out  8  mux select: 128+idx while granted, 0 (NON_FIFO_CHOOSE) while idle.
- ch_tready  out  NUM_CH  per-channel `tready` toward the FIFOs.
- busy  out  1  high while in XFER.
- pkt_done  out  1  one-cycle pulse on each `tlast` handshake.
- timeout  out  1  one-cycle pulse on a watchdog abort.
- pkt_cnt  out  CNT_W  count of completed packets; wraps.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, bus_sel=0, busy=0, pkt_done=0, timeout=0, pkt_cnt=0, beat_cnt=0.
  - last_idx=NUM_CH-1, so channel 0 has first priority after reset.
  - ch_tready=0 immediately.
- Definition: beat = axis_out_tvalid & axis_down_tready, evaluated only in XFER.
- State IDLE:
  - bus_sel=0, ch_tready=0.
  - If en=1 and ch_req≠0, select the first set ch_req bit searching last_idx+1, last_idx+2, … (mod NUM_CH).
  - Register the selected index as cur_idx; next cycle enter XFER with bus_sel=128+cur_idx and busy=1.
  - Grant latency: one clock from the ch_req edge to bus_sel valid.
  - ch_req=0 or en=0: stay in IDLE.
- State XFER:
  - ch_tready[cur_idx]=axis_down_tready (combinational pass-through); all other ch_tready bits = 0.
  - bus_sel is stable for the whole packet.
  - Each beat increments beat_cnt.
  - Beat with axis_out_tlast=1:
    - next cycle: state=IDLE, bus_sel=0, busy=0, pkt_done=1 for one cycle;
    - pkt_cnt+1 (wraps at 2^CNT_W); last_idx=cur_idx; beat_cnt=0.
  - Beat with tlast=0 and beat_cnt==MAX_BEATS-1:
    - treated as an abort: timeout=1 for one cycle, state=IDLE, last_idx=cur_idx, beat_cnt=0;
    - pkt_cnt unchanged; pkt_done not asserted.
  - tvalid=0 or tready=0: hold all state; the watchdog counts beats, not cycles.
- Inter-packet gap: at least one IDLE cycle (bus_sel=0) between consecutive grants, including back-to-back packets from the same channel.
- Boundary conditions:
  - en deasserted during XFER: the current packet completes normally; no new grant while en=0.
  - ch_req of the granted channel dropping mid-packet: ignored; the grant is held until `tlast` or timeout.
  - Single-beat packet (`tvalid`, `tready`, `tlast` in the first XFER cycle): valid; returns to IDLE next cycle.
  - Reset mid-packet: immediate return to reset values; the partial packet is abandoned, and the FIFO sees `tready` drop asynchronously.
  - NUM_CH=1: always grants channel 0 when requested.
- All outputs except ch_tready are registered.

Test Plan:
1. Reset, en=1, ch_req=4'b1111; each channel sends a 3-beat packet with tready=1 -> bus_sel sequence 128,0,129,0,130,0,131,0,128; pkt_cnt=4 after the fourth `tlast`.
2. ch_req=4'b0101, channel 0 granted; deassert tready for 5 cycles mid-packet -> bus_sel holds 128 and ch_tready=4'b0000 while stalled; after `tlast`, channel 2 is granted next (bus_sel=130), not channel 0.
3. MAX_BEATS=8; channel 1 streams 10 beats with no `tlast` -> timeout pulses one cycle after the 8th beat, bus_sel=0, pkt_cnt unchanged, next grant search starts at channel 2.
4. en=0 asserted during the second beat of a 4-beat packet on channel 3 -> packet completes with pkt_done=1; bus_sel stays 0 while en=0 even with ch_req=4'b1111.
5. rst_n pulsed low during beat 2 of a channel-2 packet -> bus_sel=0 and ch_tready=0 within the same cycle; after release with ch_req=4'b1111, channel 0 is granted first.
6. Only channel 1 requesting, two 1-beat packets back-to-back -> bus_sel 129,0,129; pkt_done pulses twice; pkt_cnt=2.

Source files
------------

// File: rtl/axis_pkt_rr_sched.sv
`default_nettype none
// ============================================================================
// axis_pkt_rr_sched : packet-level round-robin grant for an AXI-stream FIFO mux
// Revision 1.0
// ============================================================================
module axis_pkt_rr_sched #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BEATS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic              axis_out_tvalid,
  input  logic              axis_out_tlast,
  input  logic              axis_down_tready,
  output logic [7:0]        bus_sel,
  output logic [NUM_CH-1:0] ch_tready,
  output logic              busy,
  output logic              pkt_done,
  output logic              timeout,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W  = $clog2(MAX_BEATS);
  localparam logic [BC_W-1:0]  BEAT_LAST = BC_W'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [7:0]       bus_sel_q, bus_sel_d;
  logic             busy_q, busy_d;
  logic             pkt_done_q, pkt_done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [NUM_CH-1:0] w_hi_req;
  logic [NUM_CH-1:0] w_hi_first;
  logic [NUM_CH-1:0] w_lo_first;
  logic [NUM_CH-1:0] w_onehot;
  logic [NUM_CH-1:0] w_col [IDX_W];
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_vld;
  logic              w_beat;

  // Requests above the last winner take priority; otherwise wrap to the lowest.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_rr
    localparam logic [31:0] IV = i;
    assign w_hi_req[i]   = ch_req[i] & (IDX_W'(i) > last_idx_q);
    assign w_hi_first[i] = w_hi_req[i] & ~|(w_hi_req & ~({NUM_CH{1'b1}} << i));
    assign w_lo_first[i] = ch_req[i] & ~|(ch_req & ~({NUM_CH{1'b1}} << i));
    assign w_onehot[i]   = (|w_hi_req) ? w_hi_first[i] : w_lo_first[i];
    for (genvar b = 0; b < IDX_W; b++) begin : g_col
      assign w_col[b][i] = w_onehot[i] & IV[b];
    end
    assign ch_tready[i] = (state_q == S_XFER) && (cur_idx_q == IDX_W'(i)) && axis_down_tready;
  end

  for (genvar b = 0; b < IDX_W; b++) begin : g_idx
    assign w_pick_idx[b] = |w_col[b];
  end

  assign w_pick_vld = |ch_req;
  assign w_beat     = (state_q == S_XFER) && axis_out_tvalid && axis_down_tready;

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    last_idx_d = last_idx_q;
    beat_cnt_d = beat_cnt_q;
    bus_sel_d  = bus_sel_q;
    busy_d     = busy_q;
    pkt_done_d = 1'b0;
    timeout_d  = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (en && w_pick_vld) begin
          state_d    = S_XFER;
          cur_idx_d  = w_pick_idx;
          bus_sel_d  = 8'h80 | 8'(w_pick_idx);
          busy_d     = 1'b1;
          beat_cnt_d = '0;
        end
      end
      S_XFER: begin
        if (w_beat) begin
          if (axis_out_tlast) begin
            state_d    = S_IDLE;
            bus_sel_d  = 8'h00;
            busy_d     = 1'b0;
            pkt_done_d = 1'b1;
            pkt_cnt_d  = pkt_cnt_q + 1'b1;
            last_idx_d = cur_idx_q;
            beat_cnt_d = '0;
          end else if (beat_cnt_q == BEAT_LAST) begin
            // Watchdog abort: grant released without counting a packet.
            state_d    = S_IDLE;
            bus_sel_d  = 8'h00;
            busy_d     = 1'b0;
            timeout_d  = 1'b1;
            last_idx_d = cur_idx_q;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_idx_q  <= '0;
      last_idx_q <= IDX_LAST;
      beat_cnt_q <= '0;
      bus_sel_q  <= 8'h00;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      last_idx_q <= last_idx_d;
      beat_cnt_q <= beat_cnt_d;
      bus_sel_q  <= bus_sel_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
      timeout_q  <= timeout_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign bus_sel  = bus_sel_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;
  assign timeout  = timeout_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule
`default_nettype wire
